spi_peripheral: RTL

SPI mode-0 peripheral (responder) endpoint for the link driven by the team's `SPI_driver` initiator. It uses the single system clock to oversample the initiator's `SPI_CLK`, `SPI_MOSI` and active-low `SPI_EN`. It shifts an 8-bit word out on `SPI_MISO` MSB-first and delivers each received byte with a one-cycle valid pulse. It sits on the device side of the link and feeds the local register/command logic.

---
 rtl/spi_peripheral_if.sv | 23 ++
 rtl/spi_peripheral.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral_if.sv
// Local-side bus of the SPI peripheral: transmit holding register handshake,
// received byte strobe, status and sticky error flags.
interface spi_peripheral_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       err_underrun;
   logic       err_frame;
   logic       err_clr;

   modport master (
      output tx_data, tx_valid, err_clr,
      input  tx_ready, rx_data, rx_valid, busy, err_underrun, err_frame
   );

   modport slave (
      input  tx_data, tx_valid, err_clr,
      output tx_ready, rx_data, rx_valid, busy, err_underrun, err_frame
   );
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder, oversampled on clk: MSB-first byte exchange with a one-entry
// transmit holding register. Define SPI_PERIPH_ERR_EN to enable the sticky error flags.
module spi_peripheral #(
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            SPI_CLK,
   input  logic            SPI_MOSI,
   input  logic            SPI_EN,
   output logic            SPI_MISO,
   spi_peripheral_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

   logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, cs_sync_reg, fill_reg;
   logic sclk_d_reg, cs_d_reg, armed_reg;
   logic sclk_rise_reg, sclk_fall_reg, cs_fall_reg, cs_rise_reg;
   logic sclk_s, mosi_s, cs_s;

   logic [1:0] state_reg;
   logic [7:0] tx_shift_reg;
   logic [6:0] rx_shift_reg;
   logic [3:0] bit_cnt_reg;
   logic [7:0] rx_data_reg;
   logic       rx_valid_reg;
   logic [7:0] hold_data_reg;
   logic       hold_full_reg;

   logic do_load, do_rx, do_shift, do_abort, accept;

   assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
   assign cs_s   = cs_sync_reg[SYNC_STAGES-1];

   // Select synchronizer resets to "deselected"; armed_reg only sets once a genuine
   // high select has reached the last stage, so a select held low across reset is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_reg <= '0;
         mosi_sync_reg <= '0;
         cs_sync_reg   <= '1;
         fill_reg      <= '0;
         sclk_d_reg    <= 1'b0;
         cs_d_reg      <= 1'b1;
         armed_reg     <= 1'b0;
         sclk_rise_reg <= 1'b0;
         sclk_fall_reg <= 1'b0;
         cs_fall_reg   <= 1'b0;
         cs_rise_reg   <= 1'b0;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SPI_CLK};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], SPI_MOSI};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], SPI_EN};
         fill_reg      <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
         sclk_d_reg    <= sclk_s;
         cs_d_reg      <= cs_s;
         if (fill_reg[SYNC_STAGES-1] && cs_s)
            armed_reg <= 1'b1;
         sclk_rise_reg <= sclk_s && !sclk_d_reg;
         sclk_fall_reg <= !sclk_s && sclk_d_reg;
         cs_fall_reg   <= armed_reg && cs_d_reg && !cs_s;
         cs_rise_reg   <= cs_s && !cs_d_reg;
      end
   end

   always_comb begin
      do_load  = 1'b0;
      do_rx    = 1'b0;
      do_shift = 1'b0;
      do_abort = 1'b0;
      case (state_reg)
         ST_IDLE: do_load = cs_fall_reg;
         ST_SHIFT: begin
            if (cs_rise_reg) begin
               do_abort = (bit_cnt_reg != 4'd0) && (bit_cnt_reg != 4'd8);
            end else if (sclk_rise_reg) begin
               do_rx = (bit_cnt_reg < 4'd8);
            end else if (sclk_fall_reg) begin
               // A fall after a full byte reloads for a back-to-back byte
               do_load  = (bit_cnt_reg == 4'd8);
               do_shift = (bit_cnt_reg != 4'd0) && (bit_cnt_reg < 4'd8);
            end
         end
         default: ;
      endcase
   end

   assign accept = bus.tx_valid && !hold_full_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         tx_shift_reg  <= 8'h00;
         rx_shift_reg  <= 7'h00;
         bit_cnt_reg   <= 4'd0;
         rx_data_reg   <= 8'h00;
         rx_valid_reg  <= 1'b0;
         hold_data_reg <= 8'h00;
         hold_full_reg <= 1'b0;
      end else begin
         rx_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE:  if (cs_fall_reg) state_reg <= ST_LOAD;
            ST_LOAD:  state_reg <= ST_SHIFT;
            ST_SHIFT: if (cs_rise_reg) state_reg <= ST_IDLE;
            default:  state_reg <= ST_IDLE;
         endcase

         // tx_shift is loaded on entry to LOAD so MISO shows the MSB during LOAD
         if (do_load) begin
            tx_shift_reg <= hold_full_reg ? hold_data_reg : 8'h00;
            bit_cnt_reg  <= 4'd0;
            rx_shift_reg <= 7'h00;
         end else if (do_shift) begin
            tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
         end

         if (do_rx) begin
            rx_shift_reg <= {rx_shift_reg[5:0], mosi_s};
            bit_cnt_reg  <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
               rx_data_reg  <= {rx_shift_reg, mosi_s};
               rx_valid_reg <= 1'b1;
            end
         end

         if (accept)
            hold_data_reg <= bus.tx_data;
         if (do_load)
            hold_full_reg <= accept;
         else if (accept)
            hold_full_reg <= 1'b1;
      end
   end

   assign SPI_MISO     = (state_reg != ST_IDLE) && tx_shift_reg[7];
   assign bus.tx_ready = !hold_full_reg;
   assign bus.rx_data  = rx_data_reg;
   assign bus.rx_valid = rx_valid_reg;
   assign bus.busy     = !cs_s;

`ifdef SPI_PERIPH_ERR_EN
   logic err_underrun_reg, err_frame_reg;

   // Clear takes priority over a set in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_underrun_reg <= 1'b0;
         err_frame_reg    <= 1'b0;
      end else if (bus.err_clr) begin
         err_underrun_reg <= 1'b0;
         err_frame_reg    <= 1'b0;
      end else begin
         if (do_load && !hold_full_reg)
            err_underrun_reg <= 1'b1;
         if (do_abort)
            err_frame_reg <= 1'b1;
      end
   end

   assign bus.err_underrun = err_underrun_reg;
   assign bus.err_frame    = err_frame_reg;
`else
   logic unused_err;
   assign unused_err       = bus.err_clr ^ do_abort;
   assign bus.err_underrun = 1'b0;
   assign bus.err_frame    = 1'b0;
`endif
endmodule
